ids_pattern_ctrl: RTL

Control block for the IDS user-datapath module: stages the 64-bit match pattern written by software and commits it to the 7-byte matcher only at a packet boundary, pausing the input FIFO read side while it does so. It also resets the matcher on commit and keeps the packet and match hardware counters. It sits between the generic register block, which supplies the software and hardware regs, and the IDS datapath FSM, input FIFO and matcher.

---
 rtl/ids_pkg.sv | 26 ++
 rtl/ids_pattern_ctrl_if.sv | 31 +++
 rtl/ids_sat_counter.sv | 38 +++
 rtl/ids_pattern_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ids_pkg.sv
// Shared definitions for the IDS pattern control block: FSM encoding and sw_cmd bit map.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ids_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_EOP = 3'd1;
    localparam logic [2:0] ST_HOLD     = 3'd2;
    localparam logic [2:0] ST_LOAD     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_WAIT_EOP = ST_WAIT_EOP,
        S_HOLD     = ST_HOLD,
        S_LOAD     = ST_LOAD,
        S_DONE     = ST_DONE
    } state_t;

    // sw_cmd bit indices
    localparam int CMD_CLR  = 0;  // clear counters (level)
    localparam int CMD_LOAD = 1;  // load request (rising edge)
    localparam int CMD_MEN  = 2;  // count matches enable (level)

endpackage

// File: rtl/ids_pattern_ctrl_if.sv
// Bundle between register block / datapath (master) and the pattern control block (slave).
// Latency: n/a (wires only).
// Backpressure: hold is the only throttle; the datapath gates its FIFO read with !hold.
interface ids_pattern_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
);
    logic [31:0]           sw_pattern_high;
    logic [31:0]           sw_pattern_low;
    logic [31:0]           sw_cmd;
    logic                  pkt_sop;
    logic                  pkt_eop;
    logic                  match_in;
    logic                  hold;
    logic [DATA_WIDTH-1:0] pattern_out;
    logic                  matcher_rst;
    logic                  load_busy;
    logic                  load_done;
    logic [CNT_WIDTH-1:0]  pkt_count;
    logic [CNT_WIDTH-1:0]  match_count;

    modport master (
        output sw_pattern_high, sw_pattern_low, sw_cmd, pkt_sop, pkt_eop, match_in,
        input  hold, pattern_out, matcher_rst, load_busy, load_done, pkt_count, match_count
    );

    modport slave (
        input  sw_pattern_high, sw_pattern_low, sw_cmd, pkt_sop, pkt_eop, match_in,
        output hold, pattern_out, matcher_rst, load_busy, load_done, pkt_count, match_count
    );
endinterface

// File: rtl/ids_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
// Latency: increment visible one cycle after inc_i.
// Backpressure: none; stops at all-ones instead of wrapping.
module ids_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/ids_pattern_ctrl.sv
// Stages the software match pattern and commits it to the matcher only between packets; keeps pkt/match counters.
// Latency: idle commit takes 3 cycles after the request edge (hold, matcher reset, new pattern + done).
// Backpressure: asserts hold (registered) for at most 3 cycles per commit to pause the input FIFO read side.
module ids_pattern_ctrl
    import ids_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                clk,
    input  logic                reset,
    ids_pattern_ctrl_if.slave   bus
);

    logic                  cmd_load_q;
    logic                  load_req;
    logic [DATA_WIDTH-1:0] stage_q;
    logic [DATA_WIDTH-1:0] pattern_q;
    logic                  in_pkt_q;
    logic                  pending_q;
    state_t                state_q;
    logic                  hold_q;
    logic                  matcher_rst_q;
    logic                  load_done_q;
    logic                  match_inc;
    logic [CNT_WIDTH-1:0]  pkt_count;
    logic [CNT_WIDTH-1:0]  match_count;
    logic                  unused_cmd_bits;

    assign load_req        = bus.sw_cmd[CMD_LOAD] & ~cmd_load_q;
    assign unused_cmd_bits = ^bus.sw_cmd[31:3];

    // Request edge history and pattern staging (the request cycle's register values are captured)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_load_q <= 1'b0;
            stage_q    <= '0;
        end else begin
            cmd_load_q <= bus.sw_cmd[CMD_LOAD];
            if (load_req) begin
                stage_q <= {bus.sw_pattern_high, bus.sw_pattern_low};
            end
        end
    end

    // Packet-in-flight tracking; a single-word packet (sop with eop) leaves it clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_pkt_q <= 1'b0;
        end else if (bus.pkt_eop) begin
            in_pkt_q <= 1'b0;
        end else if (bus.pkt_sop) begin
            in_pkt_q <= 1'b1;
        end
    end

    // Commit FSM with registered hold / matcher reset / done / pattern outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            hold_q        <= 1'b0;
            matcher_rst_q <= 1'b0;
            load_done_q   <= 1'b0;
            pattern_q     <= '0;
            pending_q     <= 1'b0;
        end else begin
            matcher_rst_q <= 1'b0;
            load_done_q   <= 1'b0;
            // A request arriving mid-load restages and queues one more commit;
            // DONE consumes a same-cycle request directly instead.
            if (load_req && (state_q != S_IDLE) && (state_q != S_DONE)) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (load_req) begin
                        if (in_pkt_q || bus.pkt_sop) begin
                            state_q <= S_WAIT_EOP;
                        end else begin
                            state_q <= S_HOLD;
                            hold_q  <= 1'b1;
                        end
                    end
                end
                S_WAIT_EOP: begin
                    if (bus.pkt_eop) begin
                        state_q <= S_HOLD;
                        hold_q  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A packet slipped in before hold reached the FIFO: let it finish first
                    if (bus.pkt_sop) begin
                        state_q <= S_WAIT_EOP;
                        hold_q  <= 1'b0;
                    end else begin
                        state_q       <= S_LOAD;
                        matcher_rst_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    pattern_q   <= stage_q;
                    load_done_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    pending_q <= 1'b0;
                    if (pending_q || load_req) begin
                        if (in_pkt_q || bus.pkt_sop) begin
                            state_q <= S_WAIT_EOP;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= S_HOLD;
                            hold_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        hold_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

    assign match_inc = bus.pkt_eop & bus.match_in & bus.sw_cmd[CMD_MEN];

    ids_sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (bus.pkt_eop),
        .clr_i   (bus.sw_cmd[CMD_CLR]),
        .count_o (pkt_count)
    );

    ids_sat_counter #(.WIDTH(CNT_WIDTH)) u_match_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (match_inc),
        .clr_i   (bus.sw_cmd[CMD_CLR]),
        .count_o (match_count)
    );

    assign bus.hold        = hold_q;
    assign bus.pattern_out = pattern_q;
    assign bus.matcher_rst = matcher_rst_q;
    assign bus.load_done   = load_done_q;
    assign bus.load_busy   = (state_q != S_IDLE);
    assign bus.pkt_count   = pkt_count;
    assign bus.match_count = match_count;

endmodule
